// File: rtl/multdiv_sequencer_pkg.sv
// Shared types and constants for the multiply/divide cycle sequencer.
package multdiv_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int unsigned CNT_W_DEF       = 6;
  localparam int unsigned MULT_CYCLES_DEF = 32;
  localparam int unsigned DIV_CYCLES_DEF  = 32;

endpackage

// File: rtl/multdiv_sequencer_toggle_counter.sv
// Synchronous toggle-cell counter: bit i flips when enabled and all lower bits are 1.
module multdiv_sequencer_toggle_counter #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] tgl;

  // Per-bit toggle enable: AND of the enable and every lower bit.
  for (genvar i = 0; i < CNT_W; i++) begin : g_tgl
    if (i == 0) begin : g_lsb
      assign tgl[i] = en_i;
    end else begin : g_upper
      assign tgl[i] = en_i & (&cnt_q[i-1:0]);
    end
  end

  always_comb begin
    cnt_d = cnt_q ^ tgl;
    if (clr_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/multdiv_sequencer.sv
// Cycle-count controller for the iterative multiply/divide datapath.
module multdiv_sequencer
  import multdiv_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic             divisor_zero,
  output logic             load_o,
  output logic             step_o,
  output logic             op_div_o,
  output logic [CNT_W-1:0] count_o,
  output logic             busy_o,
  output logic             result_rdy_o,
  output logic             exception_o
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

  // The counter must be able to represent N-1 without wrapping.
  if ((64'd1 << CNT_W) <= 64'(MAX_CYCLES)) begin : g_cnt_w_check
    $error("multdiv_sequencer: CNT_W too small for the configured cycle counts");
  end
  if (MULT_CYCLES == 0 || DIV_CYCLES == 0) begin : g_cycles_check
    $error("multdiv_sequencer: cycle counts must be non-zero");
  end

  state_e state_q, state_d;
  logic   op_div_q, op_div_d;
  logic   dz_q, dz_d;
  logic   load_q, load_d;
  logic   step_q, step_d;
  logic   busy_q, busy_d;
  logic   rdy_q, rdy_d;
  logic   exc_q, exc_d;
  logic   cnt_clr;
  logic   cnt_en;
  logic   start;
  logic [CNT_W-1:0] last_idx;
  logic [CNT_W-1:0] cnt;

  multdiv_sequencer_toggle_counter #(
    .CNT_W (CNT_W)
  ) u_toggle_counter (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .count_o (cnt)
  );

  assign start    = ctrl_mult | ctrl_div;
  assign last_idx = (op_div_q == OP_DIV) ? DIV_LAST : MULT_LAST;

  // Next-state, operation latch and registered-output decode.
  always_comb begin
    state_d  = state_q;
    op_div_d = op_div_q;
    dz_d     = dz_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_LOAD: state_d = ((op_div_q == OP_DIV) && dz_q) ? ST_DONE : ST_RUN;
      ST_RUN: begin
        if (cnt == last_idx) begin
          state_d = ST_DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A start pulse aborts whatever is in flight; multiply wins a tie.
    if (start) begin
      state_d  = ST_LOAD;
      cnt_clr  = 1'b1;
      cnt_en   = 1'b0;
      op_div_d = ctrl_mult ? OP_MULT : OP_DIV;
      dz_d     = ~ctrl_mult & divisor_zero;
    end

    load_d = (state_d == ST_LOAD);
    step_d = (state_d == ST_RUN);
    busy_d = load_d | step_d;
    rdy_d  = (state_d == ST_DONE);
    exc_d  = rdy_d & (op_div_d == OP_DIV) & dz_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      op_div_q <= OP_MULT;
      dz_q     <= 1'b0;
      load_q   <= 1'b0;
      step_q   <= 1'b0;
      busy_q   <= 1'b0;
      rdy_q    <= 1'b0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_div_q <= op_div_d;
      dz_q     <= dz_d;
      load_q   <= load_d;
      step_q   <= step_d;
      busy_q   <= busy_d;
      rdy_q    <= rdy_d;
      exc_q    <= exc_d;
    end
  end

  assign load_o       = load_q;
  assign step_o       = step_q;
  assign op_div_o     = op_div_q;
  assign count_o      = cnt;
  assign busy_o       = busy_q;
  assign result_rdy_o = rdy_q;
  assign exception_o  = exc_q;

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Cycle-count controller for the iterative multiply/divide unit in the CPU execute stage.
- Accepts one-cycle start pulses from decode, drives the datapath with load and step strobes, and flags completion.
- The iteration counter is a synchronous toggle-cell counter; per-bit toggle enables are the AND of all lower bits.
- Consumers are the shift/add datapath (load_o, step_o, op_div_o) and pipeline stall logic (busy_o, result_rdy_o).

Parameters:
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).
- MULT_CYCLES, 32, number of step cycles for a multiply.
- DIV_CYCLES, 32, number of step cycles for a divide.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous reset, active-low; sampled on the rising edge of clk
- ctrl_mult  in  1  one-cycle pulse: start multiply
- ctrl_div  in  1  one-cycle pulse: start divide
- divisor_zero  in  1  datapath flag, valid in the cycle ctrl_div is high
- load_o  out  1  datapath loads operands / clears accumulator
- step_o  out  1  datapath performs one iteration
- op_div_o  out  1  latched operation: 1 = divide, 0 = multiply
- count_o  out  CNT_W  current iteration index, 0-based
- busy_o  out  1  high in LOAD and RUN
- result_rdy_o  out  1  one-cycle pulse when the result is valid
- exception_o  out  1  valid with result_rdy_o; 1 = divide by zero

Behaviour:
- Reset (rst = 0 at a clock edge):
  - state = IDLE; count_o = 0.
  - op_div_o, load_o, step_o, busy_o, result_rdy_o and exception_o all = 0.
  - Reset overrides any start pulse in the same cycle.
- States are IDLE, LOAD, RUN and DONE. All outputs are registered or decoded from state; none depend combinationally on inputs.
- Start decode, evaluated in every state:
  - ctrl_mult = 1 → op = mult.
  - else ctrl_div = 1 → op = div, and div-by-zero flag latched from divisor_zero.
  - Multiply has priority when both pulses arrive together.
  - A start in any state, including LOAD, RUN or DONE, aborts the current operation and enters LOAD next cycle.
  - An aborted operation never pulses result_rdy_o.
- IDLE: all strobes 0; waits for a start.
- LOAD (exactly 1 cycle):
  - load_o = 1, busy_o = 1, count cleared to 0.
  - Next state is DONE if op = div and the zero flag is latched; otherwise RUN.
- RUN:
  - step_o = 1 and busy_o = 1 every cycle.
  - count increments by 1 per cycle via the toggle-cell chain.
  - Leaves for DONE in the cycle count == N-1, where N = MULT_CYCLES or DIV_CYCLES per op_div_o.
  - Exactly N step cycles, with count values 0..N-1.
- DONE (exactly 1 cycle):
  - result_rdy_o = 1; exception_o = latched zero flag for a divide, 0 for a multiply.
  - busy_o = 0; next state IDLE.
  - count holds at N-1 in DONE, or at 0 when the divide-by-zero path skipped RUN.
- Latency, with the start sampled at edge 0:
  - LOAD occupies cycle 1; RUN occupies cycles 2..N+1; result_rdy_o is high in cycle N+2.
  - Divide by zero: result_rdy_o is high in cycle 2.
- Count wrap: count never exceeds N-1 in RUN. If 2^CNT_W ≤ N, the implementation fires an elaboration-time error.
- exception_o is 0 whenever result_rdy_o is 0.
- op_div_o holds its value from LOAD until the next start or reset.

Decomposition:
- Shared package:
  - state enum (IDLE, LOAD, RUN, DONE).
  - op encoding constants (OP_MULT = 0, OP_DIV = 1).
  - default cycle counts MULT_CYCLES = 32 and DIV_CYCLES = 32.
- One sub-module, toggle_counter:
  - parameterised CNT_W chain of toggle cells with a synchronous active-low clear and a synchronous clear input.
  - Bit i toggles when enable and all lower bits are 1.
  - Instantiated once for count_o.

Test Plan:
- Reset with rst = 0 for 2 cycles, then ctrl_mult pulse → load_o in cycle 1; step_o high in cycles 2..33 with count_o 0..31; result_rdy_o = 1 and exception_o = 0 in cycle 34; busy_o = 0 from cycle 34.
- ctrl_div with divisor_zero = 0 → op_div_o = 1; 32 step cycles; result_rdy_o in cycle 34; exception_o = 0.
- ctrl_div with divisor_zero = 1 → load_o in cycle 1, no step_o, result_rdy_o = 1 and exception_o = 1 in cycle 2.
- ctrl_mult, then ctrl_div at cycle 10 of RUN → no result_rdy_o for the multiply; LOAD in the next cycle; exactly 32 divide steps; a single result_rdy_o pulse.
- ctrl_mult and ctrl_div in the same cycle → op_div_o = 0; multiply timing as in scenario 1.
- rst = 0 asserted during RUN at count_o = 15 → next cycle all outputs 0 and state IDLE; a subsequent ctrl_mult completes normally in 34 cycles.
